// File: rtl/moisture_sensor_frontend_if.sv
// rtl/moisture_sensor_frontend_if.sv - ADC handshake and filtered sensor bundle for the moisture frontend
interface moisture_sensor_frontend_if #(
    parameter int ADC_W = 8
);
    logic             adc_req;
    logic [ADC_W-1:0] adc_data;
    logic             adc_valid;
    logic [3:0]       sensor;
    logic             sensor_valid;
    logic             sensor_fault;

    // master: the frontend (issues requests, publishes the sensor code)
    modport master (
        output adc_req, sensor, sensor_valid, sensor_fault,
        input  adc_data, adc_valid
    );

    // slave: the ADC and the pump controller side
    modport slave (
        input  adc_req, sensor, sensor_valid, sensor_fault,
        output adc_data, adc_valid
    );
endinterface

// File: rtl/moisture_sensor_frontend.sv
// rtl/moisture_sensor_frontend.sv - soil ADC poller/averager/quantizer; SENSOR_HYST_EN enables update hysteresis
module moisture_sensor_frontend #(
    parameter int ADC_W         = 8,
    parameter int AVG_LOG2      = 2,
    parameter int SAMPLE_PERIOD = 100,
    parameter int TIMEOUT       = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    moisture_sensor_frontend_if.master  bus
);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(2 ** AVG_LOG2);

    typedef enum logic [1:0] {IDLE, REQ, ACCUM, UPDATE} state_t;

    state_t             state;
    state_t             next_state;
    logic [TMR_W-1:0]   timer;
    logic [TO_W-1:0]    to_cnt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [ADC_W-1:0]   sample;
    logic               adc_req_q;
    logic [3:0]         sensor_q;
    logic               sensor_valid_q;
    logic               fault_q;

    logic               timeout_hit;
    logic [CNT_W-1:0]   cnt_next;
    logic               adc_req_d;
    logic               fault_event;
    logic [3:0]         code_new;
    logic               write_sensor;

    assign timeout_hit = (to_cnt == TO_LAST);
    assign cnt_next    = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (timer == '0) next_state = REQ;
            REQ: begin
                if (bus.adc_valid)    next_state = ACCUM;
                else if (timeout_hit) next_state = IDLE;
            end
            ACCUM:   next_state = (cnt_next == CNT_FULL) ? UPDATE : IDLE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef SENSOR_HYST_EN
    // Set until the first window completes after reset or after a fault.
    logic       first_win;
    logic [3:0] code_diff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 first_win <= 1'b1;
        else if (fault_event)       first_win <= 1'b1;
        else if (state == UPDATE)   first_win <= 1'b0;
    end
`endif

    always_comb begin
        adc_req_d   = (next_state == REQ);
        fault_event = (state == REQ) && !bus.adc_valid && timeout_hit;
        code_new    = acc[ACC_W-1 -: 4];
`ifdef SENSOR_HYST_EN
        code_diff    = (code_new >= sensor_q) ? (code_new - sensor_q) : (sensor_q - code_new);
        write_sensor = first_win || (code_diff >= 4'd2);
`else
        write_sensor = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer          <= TMR_RELOAD;
            to_cnt         <= '0;
            acc            <= '0;
            cnt            <= '0;
            sample         <= '0;
            adc_req_q      <= 1'b0;
            sensor_q       <= 4'hF;
            sensor_valid_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            if (next_state == IDLE && state != IDLE)
                timer <= TMR_RELOAD;
            else if (state == IDLE && timer != '0)
                timer <= timer - TMR_W'(1);

            if (state == REQ && next_state == REQ) to_cnt <= to_cnt + TO_W'(1);
            else                                   to_cnt <= '0;

            if (state == REQ && bus.adc_valid) sample <= bus.adc_data;

            if (fault_event || state == UPDATE) begin
                acc <= '0;
                cnt <= '0;
            end else if (state == ACCUM) begin
                acc <= acc + ACC_W'(sample);
                cnt <= cnt_next;
            end

            adc_req_q      <= adc_req_d;
            sensor_valid_q <= (state == UPDATE);

            if (fault_event) begin
                fault_q  <= 1'b1;
                sensor_q <= 4'hF;
            end else if (state == UPDATE) begin
                fault_q <= 1'b0;
                if (write_sensor) sensor_q <= code_new;
            end
        end
    end

    assign bus.adc_req      = adc_req_q;
    assign bus.sensor       = sensor_q;
    assign bus.sensor_valid = sensor_valid_q;
    assign bus.sensor_fault = fault_q;
endmodule

// File: tb/tb_moisture_sensor_frontend.sv
// tb/tb_moisture_sensor_frontend.sv - directed bench for moisture_sensor_frontend (SENSOR_HYST_EN aware)
module tb_moisture_sensor_frontend;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   n;

`ifdef SENSOR_HYST_EN
    localparam logic [3:0] W7_EXP = 4'h4;
`else
    localparam logic [3:0] W7_EXP = 4'h5;
`endif

    moisture_sensor_frontend_if #(.ADC_W(8)) bus ();

    moisture_sensor_frontend #(
        .ADC_W(8), .AVG_LOG2(2), .SAMPLE_PERIOD(8), .TIMEOUT(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(output int cnt);
        cnt = 0;
        while (bus.adc_req !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Answer one request with valid on REQ cycle dly (1 = first cycle).
    task automatic sample(input logic [7:0] d, input int dly);
        int w;
        wait_req(w);
        check("req_seen", bus.adc_req, 1);
        repeat (dly - 1) @(negedge clk);
        bus.adc_data  = d;
        bus.adc_valid = 1'b1;
        @(negedge clk);
        bus.adc_valid = 1'b0;
        check("req_drop", bus.adc_req, 0);
    endtask

    task automatic window(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input int dly0, input logic [3:0] exp);
        sample(a, dly0);
        if (dly0 == 15) check("valid_at_timeout_no_fault", bus.sensor_fault, 0);
        sample(b, 2);
        sample(c, 2);
        sample(d, 2);
        @(negedge clk);
        check("sv_early", bus.sensor_valid, 0);
        @(negedge clk);
        check("sv_pulse", bus.sensor_valid, 1);
        check("sensor_code", bus.sensor, exp);
        check("fault_clear", bus.sensor_fault, 0);
        @(negedge clk);
        check("sv_one_cycle", bus.sensor_valid, 0);
        check("sensor_hold", bus.sensor, exp);
    endtask

    initial begin
        bus.adc_data  = '0;
        bus.adc_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sensor", bus.sensor, 4'hF);
        check("rst_sv", bus.sensor_valid, 0);
        check("rst_req", bus.adc_req, 0);
        check("rst_fault", bus.sensor_fault, 0);
        reset = 1'b1;

        wait_req(n);
        check("first_req_delay", n, 8);
        window(8'h40, 8'h40, 8'h40, 8'h40, 2, 4'h4);
        window(8'hFF, 8'hFF, 8'hFF, 8'hFF, 15, 4'hF);
        window(8'h00, 8'h10, 8'h20, 8'h30, 2, 4'h1);

        // Partial window then ADC silence: fault must also discard the partial sum.
        sample(8'hFF, 2);
        sample(8'hFF, 2);
        wait_req(n);
        check("to_req_seen", bus.adc_req, 1);
        repeat (14) @(negedge clk);
        check("to_req_held", bus.adc_req, 1);
        check("to_no_fault_yet", bus.sensor_fault, 0);
        @(negedge clk);
        check("to_req_drop", bus.adc_req, 0);
        check("to_fault", bus.sensor_fault, 1);
        check("to_sensor", bus.sensor, 4'hF);
        check("to_no_sv", bus.sensor_valid, 0);
        @(negedge clk);
        check("to_no_sv2", bus.sensor_valid, 0);
        window(8'h80, 8'h80, 8'h80, 8'h80, 2, 4'h8);

        // Reset mid-window with adc_req high.
        sample(8'h40, 2);
        sample(8'h40, 2);
        wait_req(n);
        check("mr_req_high", bus.adc_req, 1);
        reset = 1'b0;
        #1;
        check("mr_req_async", bus.adc_req, 0);
        check("mr_sensor", bus.sensor, 4'hF);
        check("mr_fault", bus.sensor_fault, 0);
        check("mr_sv", bus.sensor_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        bus.adc_data  = 8'hFF;
        bus.adc_valid = 1'b1;
        @(negedge clk);
        bus.adc_valid = 1'b0;
        check("stray_no_req", bus.adc_req, 0);
        window(8'h20, 8'h20, 8'h20, 8'h20, 2, 4'h2);

        window(8'h40, 8'h40, 8'h40, 8'h40, 2, 4'h4);
        window(8'h50, 8'h50, 8'h50, 8'h50, 2, W7_EXP);
        window(8'h60, 8'h60, 8'h60, 8'h60, 2, 4'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
